// File: rtl/smem_ext_port.sv
// External SRAM test-port responder: arbitrates the single-port macro between the
// pad-side test interface (synchronised ext strobe) and the internal compute engine.
module smem_ext_port #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_smem_ext,
    input  logic              i_smem_cen,
    input  logic              i_smem_wen,
    input  logic [ADDR_W-1:0] i_smem_addr,
    input  logic [DATA_W-1:0] i_smem_wdata,
    output logic [DATA_W-1:0] o_smem_rdata,
    input  logic              i_core_req,
    input  logic              i_core_wen,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    output logic              o_core_gnt,
    output logic              o_core_rvalid,
    output logic [DATA_W-1:0] o_core_rdata,
    output logic              o_ext_mode,
    output logic              o_mem_cen,
    output logic              o_mem_wen,
    output logic [ADDR_W-1:0] o_mem_a,
    output logic [DATA_W-1:0] o_mem_d,
    input  logic [DATA_W-1:0] i_mem_q
);

    typedef enum logic [1:0] {
        ST_CORE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_EXT     = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              pcen_q, pwen_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              ext_meta_q, ext_s_q;
    logic              ext_pend_q, ext_pend_d;
    logic              core_pend_q, core_pend_d;
    logic [DATA_W-1:0] smem_rdata_q;
    logic              gnt;

    // Control state; pad strobes park inactive so reset never leaves a stray access.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pcen_q       <= 1'b1;
            pwen_q       <= 1'b1;
            ext_meta_q   <= 1'b0;
            ext_s_q      <= 1'b0;
            state_q      <= ST_CORE;
            ext_pend_q   <= 1'b0;
            core_pend_q  <= 1'b0;
            smem_rdata_q <= '0;
        end else begin
            pcen_q      <= i_smem_cen;
            pwen_q      <= i_smem_wen;
            ext_meta_q  <= i_smem_ext;
            ext_s_q     <= ext_meta_q;
            state_q     <= state_d;
            ext_pend_q  <= ext_pend_d;
            core_pend_q <= core_pend_d;
            if (ext_pend_q) begin
                smem_rdata_q <= i_mem_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        paddr_q  <= i_smem_addr;
        pwdata_q <= i_smem_wdata;
    end

    always_comb begin
        state_d   = state_q;
        gnt       = 1'b0;
        o_mem_cen = 1'b1;
        o_mem_wen = 1'b1;
        o_mem_a   = '0;
        o_mem_d   = '0;
        case (state_q)
            ST_CORE: begin
                if (ext_s_q) begin
                    state_d = ST_DRAIN;
                end
                gnt = i_core_req & ~ext_s_q;
                if (gnt) begin
                    o_mem_cen = 1'b0;
                    o_mem_wen = i_core_wen;
                    o_mem_a   = i_core_addr;
                    o_mem_d   = i_core_wdata;
                end
            end
            ST_DRAIN: state_d = ST_EXT;
            ST_EXT: begin
                if (!ext_s_q) begin
                    state_d = ST_RELEASE;
                end
                if (!pcen_q) begin
                    o_mem_cen = 1'b0;
                    o_mem_wen = pwen_q;
                    o_mem_a   = paddr_q;
                    o_mem_d   = pwdata_q;
                end
            end
            ST_RELEASE: state_d = ST_CORE;
            default:    state_d = ST_CORE;
        endcase
        // Macro pins go idle the instant reset asserts, not at the next edge.
        if (i_reset) begin
            gnt       = 1'b0;
            o_mem_cen = 1'b1;
            o_mem_wen = 1'b1;
            o_mem_a   = '0;
            o_mem_d   = '0;
        end
    end

    assign ext_pend_d    = (state_q == ST_EXT) & ~pcen_q & pwen_q;
    assign core_pend_d   = gnt & i_core_wen;

    assign o_core_gnt    = gnt;
    assign o_core_rvalid = core_pend_q;
    assign o_core_rdata  = core_pend_q ? i_mem_q : '0;
    assign o_ext_mode    = (state_q == ST_EXT);
    assign o_smem_rdata  = smem_rdata_q;

endmodule

// File: tb/tb_smem_ext_port.sv
// Bench for smem_ext_port: SRAM macro model, reference memory array and
// expectation queues popped by an independent output monitor.
module tb_smem_ext_port;
    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_smem_ext, i_smem_cen, i_smem_wen;
    logic [AW-1:0] i_smem_addr;
    logic [DW-1:0] i_smem_wdata;
    logic [DW-1:0] o_smem_rdata;
    logic          i_core_req, i_core_wen;
    logic [AW-1:0] i_core_addr;
    logic [DW-1:0] i_core_wdata;
    logic          o_core_gnt, o_core_rvalid;
    logic [DW-1:0] o_core_rdata;
    logic          o_ext_mode, o_mem_cen, o_mem_wen;
    logic [AW-1:0] o_mem_a;
    logic [DW-1:0] o_mem_d;
    logic [DW-1:0] i_mem_q;

    always #5 clk = ~clk;

    smem_ext_port #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_smem_ext(i_smem_ext), .i_smem_cen(i_smem_cen), .i_smem_wen(i_smem_wen),
        .i_smem_addr(i_smem_addr), .i_smem_wdata(i_smem_wdata), .o_smem_rdata(o_smem_rdata),
        .i_core_req(i_core_req), .i_core_wen(i_core_wen), .i_core_addr(i_core_addr),
        .i_core_wdata(i_core_wdata), .o_core_gnt(o_core_gnt), .o_core_rvalid(o_core_rvalid),
        .o_core_rdata(o_core_rdata), .o_ext_mode(o_ext_mode), .o_mem_cen(o_mem_cen),
        .o_mem_wen(o_mem_wen), .o_mem_a(o_mem_a), .o_mem_d(o_mem_d), .i_mem_q(i_mem_q)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic [DW-1:0] val;
    } ext_exp_t;

    ext_exp_t      ext_q[$];
    logic [DW-1:0] core_q[$];
    logic [DW-1:0] ref_mem[4096];
    logic          model_ext;
    logic [DW-1:0] exp_smem;

    function automatic logic [DW-1:0] init_val(int i);
        return 16'(i * 40503 + 12345);
    endfunction

    // SRAM macro: access sampled on the edge, read data valid after that edge
    logic [DW-1:0] mem[4096];
    logic [DW-1:0] mem_q;
    assign i_mem_q = mem_q;
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = init_val(i);
        mem_q = '0;
        forever begin
            @(posedge clk);
            if (!o_mem_cen) begin
                if (!o_mem_wen) mem[o_mem_a] = o_mem_d;
                else mem_q <= mem[o_mem_a];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a response
    always @(negedge clk) begin
        if (!i_reset) begin
            if (o_core_rvalid) begin
                if (core_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL core_rvalid_unexpected: got rvalid with %h expected none", o_core_rdata);
                end else begin
                    check("core_rdata", o_core_rdata, core_q.pop_front());
                end
            end
            while (ext_q.size() > 0 && ext_q[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL ext_missed: got no sample expected %h at cycle %0d", ext_q[0].val, ext_q[0].due);
                void'(ext_q.pop_front());
            end
            if (ext_q.size() > 0 && ext_q[0].due == cyc) begin
                check("smem_rdata", o_smem_rdata, ext_q.pop_front().val);
            end
        end
    end

    task automatic step(input logic req, input logic cwen, input logic [AW-1:0] caddr,
                        input logic [DW-1:0] cdata, input logic pcen, input logic pwen,
                        input logic [AW-1:0] paddr, input logic [DW-1:0] pdata,
                        input logic exp_gnt, input int exp_mode);
        i_core_req   = req;
        i_core_wen   = cwen;
        i_core_addr  = caddr;
        i_core_wdata = cdata;
        i_smem_cen   = pcen;
        i_smem_wen   = pwen;
        i_smem_addr  = paddr;
        i_smem_wdata = pdata;
        if (model_ext && !pcen) begin
            if (!pwen) ref_mem[paddr] = pdata;
            else begin
                exp_smem = ref_mem[paddr];
                ext_q.push_back('{due: cyc + 3, val: ref_mem[paddr]});
            end
        end
        @(negedge clk);
        check("core_gnt", o_core_gnt, exp_gnt);
        if (exp_mode >= 0) check("ext_mode", o_ext_mode, exp_mode[0]);
        if (exp_gnt) begin
            if (!cwen) ref_mem[caddr] = cdata;
            else core_q.push_back(ref_mem[caddr]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int exp_mode);
        step(1'b0, 1'b1, '0, '0, 1'b1, 1'b1, '0, '0, 1'b0, exp_mode);
    endtask

    task automatic pad(input logic pwen, input logic [AW-1:0] a, input logic [DW-1:0] d);
        step(1'b0, 1'b1, '0, '0, 1'b0, pwen, a, d, 1'b0, 1);
    endtask

    logic          r_req, r_wen, r_cen, r_pwen;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
        model_ext    = 1'b0;
        exp_smem     = '0;
        i_reset      = 1'b1;
        i_smem_ext   = 1'b0;
        i_smem_cen   = 1'b1;
        i_smem_wen   = 1'b1;
        i_smem_addr  = '0;
        i_smem_wdata = '0;
        i_core_req   = 1'b1;
        i_core_wen   = 1'b0;
        i_core_addr  = 12'h123;
        i_core_wdata = 16'hBEEF;

        @(negedge clk);
        check("rst_mem_cen", o_mem_cen, 1);
        check("rst_mem_wen", o_mem_wen, 1);
        check("rst_mem_a", o_mem_a, 0);
        check("rst_mem_d", o_mem_d, 0);
        check("rst_smem_rdata", o_smem_rdata, 0);
        check("rst_core_gnt", o_core_gnt, 0);
        check("rst_core_rvalid", o_core_rvalid, 0);
        check("rst_core_rdata", o_core_rdata, 0);
        check("rst_ext_mode", o_ext_mode, 0);
        @(posedge clk);
        #1;
        i_reset = 1'b0;

        // random engine traffic in CORE
        repeat (150) begin
            r_req  = 1'($urandom_range(0, 1));
            r_wen  = 1'($urandom_range(0, 1));
            r_addr = 12'($urandom_range(0, 15));
            r_data = 16'($urandom);
            step(r_req, r_wen, r_addr, r_data, 1'b1, 1'b1, '0, '0, r_req, 0);
        end

        // pad write while not in EXT must be ignored
        repeat (3) begin
            step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 12'h001, 16'hFFFF, 1'b0, 0);
            check("ignored_mem_cen", o_mem_cen, 1);
            check("ignored_smem_rdata", o_smem_rdata, exp_smem);
        end
        step(1'b1, 1'b1, 12'h001, '0, 1'b1, 1'b1, '0, '0, 1'b1, 0);

        // handover with a continuous engine read stream
        i_smem_ext = 1'b1;
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 12'h010, '0, 1'b1, 1'b1, '0, '0, (i <= 1), (i >= 4));
        model_ext = 1'b1;

        pad(1'b0, 12'h7FF, 16'hA5C3);
        pad(1'b1, 12'h7FF, '0);
        repeat (4) idle(1);
        check("smem_hold_a5c3", o_smem_rdata, 16'hA5C3);

        pad(1'b0, 12'h000, 16'h1111);
        pad(1'b0, 12'h001, 16'h2222);
        pad(1'b0, 12'h002, 16'h3333);
        pad(1'b1, 12'h000, '0);
        pad(1'b1, 12'h001, '0);
        pad(1'b1, 12'h002, '0);
        repeat (4) idle(1);
        check("smem_hold_3333", o_smem_rdata, 16'h3333);

        // random pad traffic in EXT; engine requests must never be granted
        repeat (150) begin
            r_req  = 1'($urandom_range(0, 1));
            r_cen  = 1'($urandom_range(0, 1));
            r_pwen = 1'($urandom_range(0, 1));
            r_addr = 12'($urandom_range(0, 15));
            r_data = 16'($urandom);
            step(r_req, 1'b1, r_addr, '0, r_cen, r_pwen, r_addr, r_data, 1'b0, 1);
        end

        // return to core
        model_ext  = 1'b0;
        i_smem_ext = 1'b0;
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 12'hFFF, 16'h0BEE, 1'b1, 1'b1, '0, '0, (i == 4), (i <= 2));
        step(1'b1, 1'b1, 12'hFFF, '0, 1'b1, 1'b1, '0, '0, 1'b1, 0);
        check("ret_rvalid", o_core_rvalid, 1);
        check("ret_rdata", o_core_rdata, 16'h0BEE);
        idle(0);

        // reset in the middle of an external read
        i_smem_ext = 1'b1;
        for (int i = 0; i < 6; i++) idle(i >= 4);
        model_ext = 1'b1;
        pad(1'b1, 12'h7FF, '0);
        i_reset    = 1'b1;
        i_smem_ext = 1'b0;
        i_smem_cen = 1'b1;
        #1;
        check("midrst_mem_cen", o_mem_cen, 1);
        check("midrst_mem_wen", o_mem_wen, 1);
        check("midrst_smem_rdata", o_smem_rdata, 0);
        check("midrst_ext_mode", o_ext_mode, 0);
        check("midrst_rvalid", o_core_rvalid, 0);
        ext_q.delete();
        core_q.delete();
        model_ext = 1'b0;
        exp_smem  = '0;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        step(1'b1, 1'b1, 12'h7FF, '0, 1'b1, 1'b1, '0, '0, 1'b1, 0);
        repeat (3) idle(0);

        check("core_q_drained", core_q.size(), 0);
        check("ext_q_drained", ext_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/smem_ext_port.md
# smem_ext_port

Core-side responder for the chip's external SRAM test port. It sits inside the chip core between the pad-ring inputs (`i_smem_*`) and the single-port activation/weight SRAM macro. When the external-access strobe is high it hands the macro to the pins and returns read data to the output pads; otherwise it hands the macro to the internal compute engine through a request/grant interface.

## Interface
- ADDR_W, 12, SRAM word-address width
- DATA_W, 16, SRAM data width

- i_clk  in  1  core clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_smem_ext  in  1  from pad; 1 = external owns SRAM (asynchronous to the core, synchronised here)
- i_smem_cen  in  1  from pad; active-low chip enable
- i_smem_wen  in  1  from pad; active-low write enable (0 = write, 1 = read)
- i_smem_addr  in  ADDR_W  from pad; word address
- i_smem_wdata  in  DATA_W  from pad; write data
- o_smem_rdata  out  DATA_W  to pads; last external read data
- i_core_req  in  1  engine access request
- i_core_wen  in  1  engine active-low write enable
- i_core_addr  in  ADDR_W  engine address
- i_core_wdata  in  DATA_W  engine write data
- o_core_gnt  out  1  engine access accepted this cycle
- o_core_rvalid  out  1  engine read data valid (one-cycle pulse)
- o_core_rdata  out  DATA_W  engine read data
- o_ext_mode  out  1  1 while FSM is in EXT
- o_mem_cen  out  1  macro active-low enable
- o_mem_wen  out  1  macro active-low write enable
- o_mem_a  out  ADDR_W  macro address
- o_mem_d  out  DATA_W  macro write data
- i_mem_q  in  DATA_W  macro read data, valid after the edge following the access edge

## Operation
- Input stage: cen, wen, addr and wdata are captured by one register stage each cycle. i_smem_ext passes through a 2-flop synchroniser, giving ext_s.
- FSM states: CORE, DRAIN, EXT, RELEASE. Reset state is CORE.
  - CORE -> DRAIN when ext_s=1.
  - DRAIN -> EXT unconditionally after 1 cycle. This lets an in-flight engine read complete.
  - EXT -> RELEASE when ext_s=0.
  - RELEASE -> CORE unconditionally after 1 cycle.
- In CORE:
  - o_core_gnt = i_core_req & ~ext_s.
  - The macro is driven from the core_* inputs when granted; otherwise o_mem_cen=1.
- In DRAIN and RELEASE: o_mem_cen=1, o_core_gnt=0.
- In EXT:
  - The macro is driven from the registered pad signals.
  - o_core_gnt=0.
  - Pad cen=1 leaves o_mem_cen=1.
- External accesses presented outside EXT are ignored: no macro access, and o_smem_rdata is unchanged.
- External read (registered cen=0, wen=1, in EXT): a pending flag is set, and i_mem_q is captured into the o_smem_rdata register on the next edge. The register holds its value until the next external read.
- External write: macro write only; o_smem_rdata is unchanged.
- Engine read granted: o_core_rvalid=1 on the next cycle with o_core_rdata = i_mem_q. Engine writes produce no rvalid.
- Reset (asynchronous, any state):
  - FSM returns to CORE and the pending flags clear.
  - Outputs take: o_mem_cen=1, o_mem_wen=1, o_mem_a=0, o_mem_d=0, o_smem_rdata=0, o_core_gnt=0, o_core_rvalid=0, o_core_rdata=0, o_ext_mode=0.
  - An access in progress is abandoned.

## Timing
- Pad signals sampled at edge k:
  - Macro enable asserted during cycle k..k+1, and the macro samples at edge k+1.
  - Read data appears on o_smem_rdata after edge k+2.
  - External read latency is 2 cycles, and back-to-back reads are supported at 1 per cycle.
- i_smem_ext rising before edge j:
  - ext_s=1 after edge j+1.
  - DRAIN after edge j+2.
  - EXT and o_ext_mode=1 after edge j+3.
- i_smem_ext falling: EXT is left and CORE is reached 2 cycles after ext_s falls.
- Engine read: grant in cycle c, rvalid in cycle c+1. Throughput is 1 per cycle in CORE.
- Simultaneous events:
  - i_core_req in the same cycle ext_s rises is not granted.
  - A granted read in the last CORE cycle still returns rvalid during DRAIN.
- Addresses wrap naturally at 2^ADDR_W. No bounds checking is performed.

## Test plan
- Reset: assert i_reset mid-EXT read. Required: o_mem_cen=1, o_mem_wen=1 and o_smem_rdata=0 immediately; FSM in CORE after release.
- External write then read: ext=1, write 0xA5C3 to addr 0x7FF, then read 0x7FF. Required: o_smem_rdata=0xA5C3 exactly 2 cycles after the read's sampling edge, held while cen=1.
- Mode handover: engine issues a continuous read stream to addr 0x010, then i_smem_ext rises. Required:
  - The last grant occurs before ext_s=1, and its rvalid still arrives.
  - No grant is issued in DRAIN, EXT or RELEASE.
  - o_ext_mode rises 3 edges after the ext input change.
- Ignored access: with ext=0, drive pad cen=0, wen=0, addr 0x001, data 0xFFFF. Required: macro untouched; a later engine read of 0x001 returns its prior value; o_smem_rdata unchanged.
- Back-to-back external reads of 0x000, 0x001, 0x002 (preloaded 0x1111, 0x2222, 0x3333). Required: o_smem_rdata steps through 0x1111, 0x2222, 0x3333 on consecutive cycles.
- Return to core: drop ext, then engine writes 0x0BEE to 0xFFF and reads it back. Required: grant 2 cycles after ext_s falls; rvalid with 0x0BEE.
